// File: rtl/smg_pkg.sv
// smg_pkg: shared types, constants and helpers for the seven-segment scan path
package smg_pkg;

    typedef enum logic {IDLE, CONV} state_t;

    localparam int NIB_W = 4;

    // Largest value representable in the given number of BCD digits (10^digits - 1)
    function automatic int unsigned sat_limit(input int unsigned digits);
        int unsigned v;
        v = 1;
        for (int unsigned k = 0; k < digits; k++) v = v * 10;
        return v - 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 binary to BCD converter, one bit per cycle
module bin2bcd_seq
    import smg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [BIN_W-1:0]                 bin_i,
    input  logic                             load_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic [DIGITS-1:0][NIB_W-1:0]     bcd_o
);

    localparam int                 TOT   = DIGITS * NIB_W + BIN_W;
    localparam int                 CNT_W = $clog2(BIN_W);
    localparam logic [BIN_W-1:0]   LIMIT = BIN_W'(sat_limit(DIGITS));

    state_t                         r_state;
    logic [BIN_W-1:0]               r_bin;
    logic [DIGITS-1:0][NIB_W-1:0]   r_bcd;
    logic [CNT_W-1:0]               r_cnt;
    logic [DIGITS-1:0][NIB_W-1:0]   w_adj;
    logic [TOT-1:0]                 w_next;
    logic                           w_last;

    // Add-3 correction on every nibble that would overflow past 9 after the shift
    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < DIGITS; d++)
            w_adj[d] = (r_bcd[d] >= NIB_W'(5)) ? r_bcd[d] + NIB_W'(3) : r_bcd[d];
    end

    assign w_next = {w_adj, r_bin} << 1;
    assign w_last = (r_state == CONV) && (r_cnt == CNT_W'(BIN_W - 1));
    // The final iteration's result is handed out combinationally so the display
    // register can capture it on the same edge the FSM returns to IDLE.
    assign done_o = w_last;
    assign bcd_o  = w_next[TOT-1:BIN_W];

    // Conversion FSM: accept a saturated load in IDLE, iterate BIN_W times in CONV
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            busy_o  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load_i) begin
                        r_state <= CONV;
                        busy_o  <= 1'b1;
                        r_bin   <= (bin_i > LIMIT) ? LIMIT : bin_i;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                    end
                end
                CONV: begin
                    r_bcd <= w_next[TOT-1:BIN_W];
                    r_bin <= w_next[BIN_W-1:0];
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= IDLE;
                        busy_o  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/smg_scan_control.sv
// smg_scan_control: binary load, BCD display register and time-multiplexed digit scan
module smg_scan_control
    import smg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int BIN_W    = 14,
    parameter int SCAN_DIV = 50000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [BIN_W-1:0]    bin_i,
    input  logic                load_i,
    output logic                busy_o,
    output logic [NIB_W-1:0]    dat_o,
    output logic [DIGITS-1:0]   sel_o
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIV_W-1:0]               r_div;
    logic [IDX_W-1:0]               r_idx;
    logic [DIGITS-1:0][NIB_W-1:0]   r_disp;
    logic [DIGITS-1:0]              r_sel_pre;
    logic                           w_done;
    logic [DIGITS-1:0][NIB_W-1:0]   w_bcd;
    logic                           w_wrap;

    bin2bcd_seq #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) u_conv (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .bin_i  (bin_i),
        .load_i (load_i),
        .busy_o (busy_o),
        .done_o (w_done),
        .bcd_o  (w_bcd)
    );

    assign w_wrap = (r_div == DIV_W'(SCAN_DIV - 1));

    // Free-running slot divider and digit index, independent of conversions
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_div <= '0;
            r_idx <= '0;
        end else begin
            r_div <= w_wrap ? '0 : r_div + DIV_W'(1);
            if (w_wrap)
                r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end
    end

    // Display register only changes on completion, so partial results never show
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            r_disp <= '0;
        else if (w_done)
            r_disp <= w_bcd;
    end

    // Registered digit data; select is delayed a further cycle to match the encoder
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dat_o     <= '0;
            r_sel_pre <= '1;
            sel_o     <= '1;
        end else begin
            dat_o     <= r_disp[r_idx];
            r_sel_pre <= ~(DIGITS'(1) << r_idx);
            sel_o     <= r_sel_pre;
        end
    end

endmodule

// File: doc/smg_scan_control.md
# smg_scan_control

Upstream stage of the seven-segment encoder path. It takes a binary value on a load strobe and converts it to BCD sequentially (shift-and-add-3). It holds the result in a display register and time-multiplexes the digits: one 4-bit BCD digit per scan slot goes to the encoder's `dat_i`, together with an active-low digit-select bus. The select bus is delayed one cycle so it lines up with the encoder's registered segment output.

## Interface
- `DIGITS`, 4: number of BCD digits displayed; digit 0 is the least significant.
- `BIN_W`, 14: width of the binary input; must satisfy 2^BIN_W ≥ 10^DIGITS.
- `SCAN_DIV`, 50000: clock cycles per digit slot (1 ms at 50 MHz); minimum 2.

- `clk_i`  in  1  sole clock; all logic on its rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `bin_i`  in  BIN_W  binary value to display; sampled only on an accepted load.
- `load_i`  in  1  single-cycle load strobe.
- `busy_o`  out  1  high while a conversion is in progress.
- `dat_o`  out  4  BCD digit for the current slot; drives the encoder's `dat_i`.
- `sel_o`  out  DIGITS  active-low one-hot digit enable, aligned to the encoder output.

## Operation
- Reset values:
  - `busy_o`=0, `dat_o`=0, `sel_o`=all ones (all digits off).
  - Display register = 0, digit index = 0, divider = 0, FSM = IDLE.
- FSM, two states:
  - **IDLE**:
    - `load_i`=1 moves to CONV.
    - The shift register loads min(`bin_i`, 10^DIGITS−1): out-of-range input saturates, e.g. to 9999 for 4 digits.
    - The BCD accumulator clears and the bit counter clears.
  - **CONV**, one iteration per cycle:
    - Add 3 to every BCD nibble ≥5.
    - Shift {bcd, bin} left by 1.
    - Increment the bit counter.
    - On the iteration with counter = BIN_W−1, write the final BCD into the display register and return to IDLE.
- `busy_o` is registered and equals (state == CONV).
- `load_i` asserted in CONV is ignored; it is neither queued nor restarted.
- The display register changes only on conversion completion, so partial results are never displayed.
- Scan engine, independent of the FSM:
  - The divider counts 0..SCAN_DIV−1 and wraps.
  - On wrap, the digit index increments 0..DIGITS−1 and wraps to 0.
- Each cycle, the registered `dat_o` takes display digit[index], and an internal `sel_pre` takes ~(1<<index).
- `sel_o` takes `sel_pre` one cycle later, compensating for the encoder's one-cycle latency.
- A display update mid-slot appears on `dat_o` on the next cycle for the current digit; no glitch suppression is required.
- Reset mid-conversion: all state returns to reset values immediately and the conversion is discarded.

## Timing
- `load_i` accepted at edge T:
  - `busy_o`=1 from T+1 through T+BIN_W.
  - Display register valid and `busy_o`=0 at T+BIN_W+1, i.e. after 14 busy cycles at default.
- Minimum load-to-load spacing: BIN_W+1 cycles.
- Digit-index change at edge E:
  - `dat_o` reflects the new digit at E+1.
  - `sel_o` reflects it at E+2, the same edge the encoder's segment output updates.
- Each digit is enabled for exactly SCAN_DIV cycles per frame; the frame period is DIGITS×SCAN_DIV.
- After reset release, `dat_o` shows digit 0 at the first edge.
- `sel_o` stays all ones for two edges, then enables digit 0.

## Structure
- Shared package `smg_pkg`:
  - FSM state enum (IDLE, CONV).
  - BCD nibble width constant (4).
  - Saturation limit function 10^DIGITS−1.
- Sub-module `bin2bcd_seq`:
  - Contains the FSM, shift/add-3 datapath, `busy_o` and a done pulse.
  - The top level instantiates it and owns the display register, divider, digit index and output registers.

## Test plan
- Reset, SCAN_DIV=4:
  - `sel_o`=4'b1111 for two edges, then 4'b1110.
  - `dat_o`=0 and `busy_o`=0 throughout.
- Load 1234:
  - `busy_o` high exactly 14 cycles.
  - Scan then gives `dat_o` 4,3,2,1 with `sel_o` 1110,1101,1011,0111, each slot 4 cycles and `sel_o` lagging `dat_o` by 1 cycle.
- Load 10000 and load 16383 → display 9999; load 0 → all digits 0; load 9999 → 9999.
- Load 5678 then pulse `load_i` with 42 at busy cycle 5 → second load ignored, display 5678, `busy_o` drops after 14 cycles.
- Assert `rst_i` low at busy cycle 7 of a conversion of 4321:
  - Outputs return to reset values asynchronously.
  - Display reads 0 after release; no partial digits appear.
- Run 3 full frames: digit index wraps 3→0 with no skipped or repeated slot, and each `sel_o` value holds exactly SCAN_DIV cycles.
